maxpool2x2_stream: RTL and testbench
====================================

# maxpool2x2_stream

Streaming 2x2, stride-2 max-pooling stage that consumes the raster-order pixel stream produced by a convolution feature-map block (`data_out`/`valid_out`) and emits the pooled feature map in raster order. It sits directly downstream of each feature-map stage in the conv layer. An optional ReLU is applied at the output. A single half-width line buffer holds the horizontal maxima of even rows until the matching odd row arrives.

## Interface

Parameters:
- `DATA_WIDTH`, 24, pixel width, signed two's complement
- `IMG_WIDTH`, 28, input pixels per row
- `IMG_HEIGHT`, 28, input rows per frame
- `ENABLE_RELU`, 0, when 1 the output is clamped to `max(0, pool)`

Ports:
- `clk`  in  1  clock; all logic is on the rising edge
- `rst`  in  1  reset, synchronous, active-low
- `data_in`  in  DATA_WIDTH  input pixel, raster order
- `valid_in`  in  1  `data_in` is valid this cycle
- `data_out`  out  DATA_WIDTH  pooled pixel
- `valid_out`  out  1  single-cycle strobe per pooled pixel

## Operation

- Counters `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1) advance only on cycles with `valid_in`=1.
  - `col` wraps to 0 at IMG_WIDTH-1 and `row` increments.
  - At row IMG_HEIGHT-1, col IMG_WIDTH-1, both counters wrap to 0 and the next frame begins with no idle cycle required.
- Even `col`: `data_in` is latched into register `prev`.
- Odd `col`: `hmax = smax(prev, data_in)`.
  - Even `row`: `hmax` is written to `linebuf[col>>1]`.
  - Odd `row`: `pool = smax(linebuf[col>>1], hmax)`. The result is registered to `data_out` with `valid_out`=1.
- All comparisons are signed. On a tie, either operand is acceptable because the values are equal.
- ReLU, when enabled: if `pool[DATA_WIDTH-1]`=1, output 0; otherwise output `pool`.
- Odd dimensions: the trailing column or row never completes a pair and is silently discarded. Output frame size is floor(W/2) x floor(H/2).
- The line buffer depth is IMG_WIDTH/2 (floor). It is not cleared between frames, because every entry is written before it is read.
- `valid_in` gaps of any length are allowed. All state holds while `valid_in`=0.
- No backpressure: downstream must accept every `valid_out` strobe.

## Timing

- Reset (`rst`=0 at a clock edge): `data_out`=0, `valid_out`=0, `col`=0, `row`=0, `prev`=0. Line buffer contents are don't-care.
- Reset mid-frame discards the partial frame. The first `valid_in` after `rst` returns high is pixel (0,0).
- Latency: `valid_out` rises exactly 1 cycle after the `valid_in` beat carrying an odd-row, odd-column pixel.
- `valid_out` is low on every other cycle. `data_out` holds its last value between strobes.
- Maximum throughput: 1 input pixel per cycle. Output rate is at most 1 strobe per 2 input beats within an odd row.
- A line-buffer read and write never collide: even rows only write and odd rows only read.

## Structure

- Shared package `cnn_pkg`: the `DATA_WIDTH` default (24) and a signed-max function `smax` that is reused by later pooling and activation stages.
- Sub-module `pool_line_buffer`: single-port register array, depth IMG_WIDTH/2, width DATA_WIDTH, with synchronous write and combinational read. It is separate so it can later be mapped to block RAM.
- The top level holds the counters, the `prev` register, comparators, ReLU, and the output register.

## Test plan

- 4x4 frame, pixels 1..16 in raster order, `valid_in` continuous, RELU=0 -> outputs 6, 8, 14, 16, each strobed 1 cycle after input beats 6, 8, 14, 16.
- Negative data: 4x4 frame, all pixels = -5 (0xFFFFFB). With RELU=0 -> four outputs of -5. With RELU=1 -> four outputs of 0.
- Mixed sign: block {-3, 7, 2, -9} -> 7. Block {-8, -2, -4, -6} -> -2 with RELU=0, 0 with RELU=1.
- Random `valid_in` gaps (~50% duty) on the 1..16 frame -> same four values in order, and no strobe on any gap cycle.
- Back-to-back 4x4 frames (1..16 then 17..32) with no idle cycle -> 6, 8, 14, 16, 22, 24, 30, 32.
- Assert `rst`=0 after 7 pixels, release, then send the 1..16 frame -> no output before the new frame, then 6, 8, 14, 16.
- Odd size W=5, H=5, pixels 1..25 -> outputs 7, 9, 17, 19. The last column and last row produce no strobe.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared definitions for the CNN datapath stages.
//   DATA_WIDTH_DEFAULT : default feature-map pixel width (signed two's complement)
//   SMAX_WIDTH         : operand width of smax; narrower operands are sign-extended
//                        into it and the result truncated back by the caller
//   smax(a, b)         : signed maximum, reused by pooling and activation stages
package cnn_pkg;

    localparam int DATA_WIDTH_DEFAULT = 24;
    localparam int SMAX_WIDTH         = 64;

    // Operands arrive sign-extended to SMAX_WIDTH so one function serves every
    // pixel width up to 64 bits; truncating the result back is lossless because
    // the winner is one of the two inputs.
    function automatic logic signed [SMAX_WIDTH-1:0] smax(
        input logic signed [SMAX_WIDTH-1:0] a,
        input logic signed [SMAX_WIDTH-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer
// Single-port register array holding one row of horizontal maxima.
// Synchronous write, combinational read; kept separate so it can later be
// mapped onto block RAM.
//   clk   : clock, rising edge
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : read data at addr (combinational)
module pool_line_buffer #(
    parameter int DEPTH      = 14,
    parameter int WIDTH      = 24,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream
// Streaming 2x2 / stride-2 max-pool over a raster-order pixel stream, with an
// optional ReLU on the pooled result.
//   clk       : clock, rising edge
//   rst       : synchronous, active-low reset
//   data_in   : input pixel (signed), raster order
//   valid_in  : data_in valid this cycle; all state holds when low
//   data_out  : pooled pixel (signed), held between strobes
//   valid_out : one-cycle strobe per pooled pixel
module maxpool2x2_stream
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28,
    parameter int ENABLE_RELU = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out
);

    localparam int HALF_WIDTH = IMG_WIDTH / 2;
    localparam int COL_W      = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W      = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int ADDR_W     = (HALF_WIDTH > 1) ? $clog2(HALF_WIDTH) : 1;

    logic [COL_W-1:0]             col;
    logic [ROW_W-1:0]             row;
    logic signed [DATA_WIDTH-1:0] prev;
    logic signed [DATA_WIDTH-1:0] hmax;
    logic signed [DATA_WIDTH-1:0] pool;
    logic signed [DATA_WIDTH-1:0] pool_act;
    logic [DATA_WIDTH-1:0]        lb_rdata;
    logic [ADDR_W-1:0]            lb_addr;
    logic                         lb_we;
    logic                         pair_done;
    logic                         last_col;
    logic                         last_row;

    // An odd column closes a horizontal pair. With an odd image width the
    // trailing even column never pairs up, and with an odd height the trailing
    // row is even, so it only writes the buffer and never strobes.
    assign pair_done = valid_in & col[0];
    assign lb_we     = pair_done & ~row[0];
    assign lb_addr   = ADDR_W'(col >> 1);
    assign last_col  = (col == COL_W'(IMG_WIDTH - 1));
    assign last_row  = (row == ROW_W'(IMG_HEIGHT - 1));

    pool_line_buffer #(
        .DEPTH      (HALF_WIDTH),
        .WIDTH      (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_W)
    ) u_line_buffer (
        .clk   (clk),
        .we    (lb_we),
        .addr  (lb_addr),
        .wdata (hmax),
        .rdata (lb_rdata)
    );

    // Horizontal max of the current pair, vertical max against the stored even
    // row, then the optional clamp of negative results to zero.
    always_comb begin
        hmax     = DATA_WIDTH'(smax(SMAX_WIDTH'(prev), SMAX_WIDTH'($signed(data_in))));
        pool     = DATA_WIDTH'(smax(SMAX_WIDTH'($signed(lb_rdata)), SMAX_WIDTH'(hmax)));
        pool_act = pool;
        if ((ENABLE_RELU != 0) && pool[DATA_WIDTH-1]) begin
            pool_act = '0;
        end
    end

    // Position counters, left-pixel register and output register. Everything
    // advances only on valid beats; valid_out is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col       <= '0;
            row       <= '0;
            prev      <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            if (valid_in) begin
                if (!col[0]) begin
                    prev <= $signed(data_in);
                end
                if (pair_done && row[0]) begin
                    data_out  <= pool_act;
                    valid_out <= 1'b1;
                end
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb_maxpool2x2_stream
// Directed bench: a 4x4 plain instance and a 4x4 ReLU instance share one input
// stream; a separate 5x5 instance covers odd frame dimensions.
module tb_maxpool2x2_stream;

    typedef logic signed [23:0] pix_t;
    typedef pix_t frame16_t [16];
    typedef pix_t quad_t [4];

    logic        clk;
    logic        rst;
    logic [23:0] data_in;
    logic        valid_in;
    logic [23:0] data_out;
    logic        valid_out;
    logic [23:0] relu_data_out;
    logic        relu_valid_out;
    logic [23:0] odd_data_in;
    logic        odd_valid_in;
    logic [23:0] odd_data_out;
    logic        odd_valid_out;

    int   total;
    int   bad;
    pix_t last_exp;
    pix_t last_exp_relu;
    pix_t last_exp_odd;

    maxpool2x2_stream #(.DATA_WIDTH(24), .IMG_WIDTH(4), .IMG_HEIGHT(4), .ENABLE_RELU(0)) u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out)
    );

    maxpool2x2_stream #(.DATA_WIDTH(24), .IMG_WIDTH(4), .IMG_HEIGHT(4), .ENABLE_RELU(1)) u_relu (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .data_out(relu_data_out), .valid_out(relu_valid_out)
    );

    maxpool2x2_stream #(.DATA_WIDTH(24), .IMG_WIDTH(5), .IMG_HEIGHT(5), .ENABLE_RELU(0)) u_odd (
        .clk(clk), .rst(rst), .data_in(odd_data_in), .valid_in(odd_valid_in),
        .data_out(odd_data_out), .valid_out(odd_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pix_t s(input int v);
        return 24'(v);
    endfunction

    // Drive one cycle of the shared 4x4 stream; returns 1 time unit after the edge.
    task automatic applyStimulus(input pix_t px, input logic v);
        data_in  = px;
        valid_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic applyOdd(input pix_t px, input logic v);
        odd_data_in  = px;
        odd_valid_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic exp_v, input pix_t exp_d, input pix_t exp_rd);
        total++;
        assert (valid_out === exp_v) else begin
            bad++;
            $error("[TB] FAIL %s valid_out observed=%0b expected=%0b", tag, valid_out, exp_v);
        end
        total++;
        assert (data_out === exp_d) else begin
            bad++;
            $error("[TB] FAIL %s data_out observed=%0d expected=%0d", tag, $signed(data_out), exp_d);
        end
        total++;
        assert (relu_valid_out === exp_v) else begin
            bad++;
            $error("[TB] FAIL %s relu valid_out observed=%0b expected=%0b", tag, relu_valid_out, exp_v);
        end
        total++;
        assert (relu_data_out === exp_rd) else begin
            bad++;
            $error("[TB] FAIL %s relu data_out observed=%0d expected=%0d", tag, $signed(relu_data_out), exp_rd);
        end
    endtask

    task automatic checkOdd(input string tag, input logic exp_v, input pix_t exp_d);
        total++;
        assert (odd_valid_out === exp_v) else begin
            bad++;
            $error("[TB] FAIL %s odd valid_out observed=%0b expected=%0b", tag, odd_valid_out, exp_v);
        end
        total++;
        assert (odd_data_out === exp_d) else begin
            bad++;
            $error("[TB] FAIL %s odd data_out observed=%0d expected=%0d", tag, $signed(odd_data_out), exp_d);
        end
    endtask

    // Sends one 4x4 frame. A strobe is expected right after each odd-row,
    // odd-column beat; every other cycle (gaps included) must be quiet with
    // data_out still holding the previous pooled value.
    task automatic runFrame4(input string tag, input frame16_t px, input quad_t exp_q,
                             input quad_t exp_rq, input bit gaps);
        int k;
        int ngap;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            ngap = 0;
            if (gaps) ngap = (i % 3 == 1) ? 1 : ((i % 5 == 0) ? 2 : 0);
            for (int g = 0; g < ngap; g++) begin
                applyStimulus(s(999), 1'b0);
                checkOutput({tag, " gap"}, 1'b0, last_exp, last_exp_relu);
            end
            applyStimulus(px[i], 1'b1);
            if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1)) begin
                last_exp      = exp_q[k];
                last_exp_relu = exp_rq[k];
                k++;
                checkOutput({tag, " strobe"}, 1'b1, last_exp, last_exp_relu);
            end else begin
                checkOutput({tag, " quiet"}, 1'b0, last_exp, last_exp_relu);
            end
        end
    endtask

    task automatic doReset(input string tag);
        rst = 1'b0;
        applyStimulus(s(0), 1'b0);
        rst = 1'b1;
        last_exp      = s(0);
        last_exp_relu = s(0);
        last_exp_odd  = s(0);
        checkOutput(tag, 1'b0, s(0), s(0));
        checkOdd(tag, 1'b0, s(0));
    endtask

    initial begin
        frame16_t f;
        quad_t    q;
        quad_t    qr;
        int       k;

        total         = 0;
        bad           = 0;
        rst           = 1'b0;
        data_in       = '0;
        valid_in      = 1'b0;
        odd_data_in   = '0;
        odd_valid_in  = 1'b0;
        last_exp      = s(0);
        last_exp_relu = s(0);
        last_exp_odd  = s(0);

        applyStimulus(s(0), 1'b0);
        applyStimulus(s(0), 1'b0);
        doReset("reset");

        // Ascending 1..16, continuous.
        for (int i = 0; i < 16; i++) f[i] = s(i + 1);
        q  = '{s(6), s(8), s(14), s(16)};
        runFrame4("ramp", f, q, q, 1'b0);

        // All -5: ReLU clamps every output to 0.
        for (int i = 0; i < 16; i++) f[i] = s(-5);
        q  = '{s(-5), s(-5), s(-5), s(-5)};
        qr = '{s(0), s(0), s(0), s(0)};
        runFrame4("neg", f, q, qr, 1'b0);

        // Mixed sign blocks: {-3,7,2,-9}->7, {-8,-2,-4,-6}->-2, {0,0,-1,-1}->0, {100,-100,-100,-50}->100.
        f  = '{s(-3), s(7),  s(-8),   s(-2),
               s(2),  s(-9), s(-4),   s(-6),
               s(0),  s(0),  s(100),  s(-100),
               s(-1), s(-1), s(-100), s(-50)};
        q  = '{s(7), s(-2), s(0), s(100)};
        qr = '{s(7), s(0),  s(0), s(100)};
        runFrame4("mixed", f, q, qr, 1'b0);

        // Ramp again with idle gaps between beats.
        for (int i = 0; i < 16; i++) f[i] = s(i + 1);
        q  = '{s(6), s(8), s(14), s(16)};
        runFrame4("gaps", f, q, q, 1'b1);

        // Back-to-back frames 1..16 then 17..32.
        runFrame4("b2b0", f, q, q, 1'b0);
        for (int i = 0; i < 16; i++) f[i] = s(i + 17);
        q  = '{s(22), s(24), s(30), s(32)};
        runFrame4("b2b1", f, q, q, 1'b0);

        // Partial frame of 7 pixels, reset, then a clean frame.
        for (int i = 0; i < 7; i++) applyStimulus(s(i + 1), 1'b1);
        doReset("midreset");
        for (int g = 0; g < 3; g++) begin
            applyStimulus(s(77), 1'b0);
            checkOutput("postreset idle", 1'b0, s(0), s(0));
        end
        for (int i = 0; i < 16; i++) f[i] = s(i + 1);
        q  = '{s(6), s(8), s(14), s(16)};
        runFrame4("afterreset", f, q, q, 1'b0);
        applyStimulus(s(0), 1'b0);

        // 5x5 frame twice: trailing column and row never strobe.
        for (int rep = 0; rep < 2; rep++) begin
            q = '{s(7), s(9), s(17), s(19)};
            k = 0;
            for (int i = 0; i < 25; i++) begin
                applyOdd(s(i + 1), 1'b1);
                if (((i / 5) % 2 == 1) && ((i % 5) % 2 == 1) && ((i % 5) < 4) && ((i / 5) < 4)) begin
                    last_exp_odd = q[k];
                    k++;
                    checkOdd("odd strobe", 1'b1, last_exp_odd);
                end else begin
                    checkOdd("odd quiet", 1'b0, last_exp_odd);
                end
            end
        end
        applyOdd(s(0), 1'b0);
        checkOdd("odd tail", 1'b0, last_exp_odd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
